// File: rtl/longp_wbck_arb_if.sv
// Long-pipe write-back bundle: LSU/MDU completion handshakes, ALU write-port
// sharing, long-pipe regfile write port and OITF retire request.
interface longp_wbck_arb_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
);
    logic            lsu_wbck_valid;
    logic            lsu_wbck_ready;
    logic [RAW-1:0]  lsu_wbck_rdidx;
    logic            lsu_wbck_rdwen;
    logic [XLEN-1:0] lsu_wbck_wdata;

    logic            mdu_wbck_valid;
    logic            mdu_wbck_ready;
    logic [RAW-1:0]  mdu_wbck_rdidx;
    logic            mdu_wbck_rdwen;
    logic [XLEN-1:0] mdu_wbck_wdata;

    logic            alu_wbck_valid;
    logic            alu_wbck_ready;

    logic            rf_wen;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic            clr_req;
    logic [RAW-1:0]  clr_idx;

    // Arbiter side.
    modport slave (
        input  lsu_wbck_valid, lsu_wbck_rdidx, lsu_wbck_rdwen, lsu_wbck_wdata,
        output lsu_wbck_ready,
        input  mdu_wbck_valid, mdu_wbck_rdidx, mdu_wbck_rdwen, mdu_wbck_wdata,
        output mdu_wbck_ready,
        input  alu_wbck_valid,
        output alu_wbck_ready,
        output rf_wen, rf_waddr, rf_wdata,
        output clr_req, clr_idx
    );

    // Producer / consumer side.
    modport master (
        output lsu_wbck_valid, lsu_wbck_rdidx, lsu_wbck_rdwen, lsu_wbck_wdata,
        input  lsu_wbck_ready,
        output mdu_wbck_valid, mdu_wbck_rdidx, mdu_wbck_rdwen, mdu_wbck_wdata,
        input  mdu_wbck_ready,
        output alu_wbck_valid,
        input  alu_wbck_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        input  clr_req, clr_idx
    );
endinterface

// File: rtl/longp_wbck_arb.sv
// Round-robin LSU/MDU write-back arbiter feeding a single registered commit stage
// that shares the regfile port with the ALU and retires one OITF entry per commit.
module longp_wbck_arb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RAW        = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    longp_wbck_arb_if.slave bus_io
);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic            wb_vld_q, wb_vld_d;
    logic [RAW-1:0]  wb_rdidx_q, wb_rdidx_d;
    logic            wb_rdwen_q, wb_rdwen_d;
    logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;

    logic force_commit;
    logic commit;
    logic load_en;
    logic grant_lsu;
    logic grant_mdu;
    logic lsu_hs;
    logic mdu_hs;

    // The ALU is only held off once the staged entry has waited STARVE_MAX cycles.
    assign force_commit = wb_vld_q & (starve_cnt_q == StarveMax);
    assign commit       = wb_vld_q & (~bus_io.alu_wbck_valid | force_commit);
    assign load_en      = ~wb_vld_q | commit;

    assign grant_lsu = bus_io.lsu_wbck_valid & (~bus_io.mdu_wbck_valid | ~rr_ptr_q);
    assign grant_mdu = bus_io.mdu_wbck_valid & (~bus_io.lsu_wbck_valid | rr_ptr_q);
    assign lsu_hs    = load_en & grant_lsu;
    assign mdu_hs    = load_en & grant_mdu;

    assign bus_io.lsu_wbck_ready = lsu_hs;
    assign bus_io.mdu_wbck_ready = mdu_hs;
    assign bus_io.alu_wbck_ready = ~force_commit;

    assign bus_io.clr_req  = commit;
    assign bus_io.clr_idx  = wb_rdidx_q;
    assign bus_io.rf_wen   = commit & wb_rdwen_q & (wb_rdidx_q != '0);
    assign bus_io.rf_waddr = wb_rdidx_q;
    assign bus_io.rf_wdata = wb_wdata_q;

    always_comb begin
        wb_vld_d     = wb_vld_q;
        wb_rdidx_d   = wb_rdidx_q;
        wb_rdwen_d   = wb_rdwen_q;
        wb_wdata_d   = wb_wdata_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;

        if (lsu_hs) begin
            wb_vld_d   = 1'b1;
            wb_rdidx_d = bus_io.lsu_wbck_rdidx;
            wb_rdwen_d = bus_io.lsu_wbck_rdwen;
            wb_wdata_d = bus_io.lsu_wbck_wdata;
            rr_ptr_d   = 1'b1;
        end else if (mdu_hs) begin
            wb_vld_d   = 1'b1;
            wb_rdidx_d = bus_io.mdu_wbck_rdidx;
            wb_rdwen_d = bus_io.mdu_wbck_rdwen;
            wb_wdata_d = bus_io.mdu_wbck_wdata;
            rr_ptr_d   = 1'b0;
        end else if (commit) begin
            wb_vld_d = 1'b0;
        end

        // A refilled entry starts its wait from zero.
        if (!wb_vld_q || commit) begin
            starve_cnt_d = '0;
        end else if (bus_io.alu_wbck_valid && !force_commit && starve_cnt_q < StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_vld_q     <= 1'b0;
            wb_rdidx_q   <= '0;
            wb_rdwen_q   <= 1'b0;
            wb_wdata_q   <= '0;
            rr_ptr_q     <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            wb_vld_q     <= wb_vld_d;
            wb_rdidx_q   <= wb_rdidx_d;
            wb_rdwen_q   <= wb_rdwen_d;
            wb_wdata_q   <= wb_wdata_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_longp_wbck_arb.sv
// Directed bench for longp_wbck_arb: accepted completions go into a scoreboard and
// every clr_req pops and checks one entry, alongside directed cycle checks.
module tb_longp_wbck_arb;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RAW  = 5;

    typedef struct {
        logic [RAW-1:0]  idx;
        logic            wen;
        logic [XLEN-1:0] data;
    } entry_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    entry_t sb[$];

    longp_wbck_arb_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

    longp_wbck_arb #(
        .XLEN      (XLEN),
        .RAW       (RAW),
        .STARVE_MAX(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lsu(input logic v, input logic [RAW-1:0] idx, input logic wen,
                             input logic [XLEN-1:0] data);
        bus.lsu_wbck_valid = v;
        bus.lsu_wbck_rdidx = idx;
        bus.lsu_wbck_rdwen = wen;
        bus.lsu_wbck_wdata = data;
    endtask

    task automatic drive_mdu(input logic v, input logic [RAW-1:0] idx, input logic wen,
                             input logic [XLEN-1:0] data);
        bus.mdu_wbck_valid = v;
        bus.mdu_wbck_rdidx = idx;
        bus.mdu_wbck_rdwen = wen;
        bus.mdu_wbck_wdata = data;
    endtask

    task automatic push(input logic [RAW-1:0] idx, input logic wen, input logic [XLEN-1:0] data);
        entry_t e;
        e.idx  = idx;
        e.wen  = wen;
        e.data = data;
        sb.push_back(e);
    endtask

    // Commit monitor: each retire must match the oldest accepted completion.
    always @(negedge clk) begin
        entry_t e;
        if (rst === 1'b1) begin
            if (bus.clr_req === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(bus.clr_idx), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_clr_idx", 64'(bus.clr_idx), 64'(e.idx));
                    check("sb_rf_wen", 64'(bus.rf_wen), 64'(e.wen && e.idx != 0));
                    if (e.wen && e.idx != 0) begin
                        check("sb_rf_waddr", 64'(bus.rf_waddr), 64'(e.idx));
                        check("sb_rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
                    end
                end
            end else begin
                check("rf_wen_idle", 64'(bus.rf_wen), 64'd0);
            end
        end
    end

    initial begin
        int lc;
        int mc;
        logic exp_l;
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.alu_wbck_valid = 1'b0;
        drive_lsu(1'b0, '0, 1'b0, '0);
        drive_mdu(1'b0, '0, 1'b0, '0);

        // Reset state.
        step();
        step();
        @(negedge clk);
        check("rst_clr_req", 64'(bus.clr_req), 64'd0);
        check("rst_rf_wen", 64'(bus.rf_wen), 64'd0);
        check("rst_alu_ready", 64'(bus.alu_wbck_ready), 64'd1);
        check("rst_lsu_ready_idle", 64'(bus.lsu_wbck_ready), 64'd0);
        bus.mdu_wbck_valid = 1'b1;
        #1;
        check("rst_mdu_ready", 64'(bus.mdu_wbck_ready), 64'd1);
        check("rst_lsu_ready", 64'(bus.lsu_wbck_ready), 64'd0);
        bus.mdu_wbck_valid = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Single LSU completion.
        drive_lsu(1'b1, 5'd5, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_lsu_ready", 64'(bus.lsu_wbck_ready), 64'd1);
        check("t1_c0_clr_req", 64'(bus.clr_req), 64'd0);
        push(5'd5, 1'b1, 32'hDEADBEEF);
        step();
        drive_lsu(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("t1_rf_wen", 64'(bus.rf_wen), 64'd1);
        check("t1_rf_waddr", 64'(bus.rf_waddr), 64'd5);
        check("t1_rf_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        check("t1_clr_req", 64'(bus.clr_req), 64'd1);
        check("t1_clr_idx", 64'(bus.clr_idx), 64'd5);
        step();
        @(negedge clk);
        check("t1_c2_rf_wen", 64'(bus.rf_wen), 64'd0);
        check("t1_c2_clr_req", 64'(bus.clr_req), 64'd0);
        step();

        // MDU commits with no regfile write: rd = x0, then rdwen = 0.
        drive_mdu(1'b1, 5'd0, 1'b1, 32'h1234);
        @(negedge clk);
        check("t4a_mdu_ready", 64'(bus.mdu_wbck_ready), 64'd1);
        push(5'd0, 1'b1, 32'h1234);
        step();
        drive_mdu(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("t4a_rf_wen", 64'(bus.rf_wen), 64'd0);
        check("t4a_clr_req", 64'(bus.clr_req), 64'd1);
        check("t4a_clr_idx", 64'(bus.clr_idx), 64'd0);
        step();
        drive_mdu(1'b1, 5'd3, 1'b0, 32'h5678);
        @(negedge clk);
        check("t4b_mdu_ready", 64'(bus.mdu_wbck_ready), 64'd1);
        push(5'd3, 1'b0, 32'h5678);
        step();
        drive_mdu(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("t4b_rf_wen", 64'(bus.rf_wen), 64'd0);
        check("t4b_clr_req", 64'(bus.clr_req), 64'd1);
        check("t4b_clr_idx", 64'(bus.clr_idx), 64'd3);
        step();

        // Both sources held valid: strict alternation, no bubbles.
        lc = 0;
        mc = 0;
        for (int k = 0; k < 4; k++) begin
            drive_lsu(1'b1, 5'(10 + lc), 1'b1, 32'hA000 + 32'(lc));
            drive_mdu(1'b1, 5'(20 + mc), 1'b1, 32'hB000 + 32'(mc));
            @(negedge clk);
            exp_l = (k % 2 == 0);
            check("t2_lsu_ready", 64'(bus.lsu_wbck_ready), 64'(exp_l));
            check("t2_mdu_ready", 64'(bus.mdu_wbck_ready), 64'(!exp_l));
            check("t2_clr_req", 64'(bus.clr_req), 64'(k != 0));
            if (exp_l) begin
                push(5'(10 + lc), 1'b1, 32'hA000 + 32'(lc));
                lc++;
            end else begin
                push(5'(20 + mc), 1'b1, 32'hB000 + 32'(mc));
                mc++;
            end
            step();
        end
        drive_lsu(1'b0, '0, 1'b0, '0);
        drive_mdu(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("t2_last_clr_req", 64'(bus.clr_req), 64'd1);
        check("t2_last_clr_idx", 64'(bus.clr_idx), 64'd21);
        step();
        @(negedge clk);
        check("t2_drain_clr_req", 64'(bus.clr_req), 64'd0);
        step();

        // Starvation: ALU held valid, forced commit on the 5th cycle.
        bus.alu_wbck_valid = 1'b1;
        drive_lsu(1'b1, 5'd7, 1'b1, 32'h77);
        @(negedge clk);
        check("t3_lsu_ready", 64'(bus.lsu_wbck_ready), 64'd1);
        push(5'd7, 1'b1, 32'h77);
        step();
        drive_lsu(1'b0, '0, 1'b0, '0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t3_blk_clr_req", 64'(bus.clr_req), 64'd0);
            check("t3_blk_alu_ready", 64'(bus.alu_wbck_ready), 64'd1);
            step();
        end
        @(negedge clk);
        check("t3_force_alu_ready", 64'(bus.alu_wbck_ready), 64'd0);
        check("t3_force_rf_wen", 64'(bus.rf_wen), 64'd1);
        check("t3_force_clr_req", 64'(bus.clr_req), 64'd1);
        check("t3_force_clr_idx", 64'(bus.clr_idx), 64'd7);
        step();
        bus.alu_wbck_valid = 1'b0;
        @(negedge clk);
        check("t3_after_clr_req", 64'(bus.clr_req), 64'd0);
        check("t3_after_alu_ready", 64'(bus.alu_wbck_ready), 64'd1);
        step();

        // Blocked stage back-pressures the MDU until the forced commit.
        bus.alu_wbck_valid = 1'b1;
        drive_lsu(1'b1, 5'd8, 1'b1, 32'h88);
        @(negedge clk);
        check("t5_lsu_ready", 64'(bus.lsu_wbck_ready), 64'd1);
        push(5'd8, 1'b1, 32'h88);
        step();
        drive_lsu(1'b0, '0, 1'b0, '0);
        drive_mdu(1'b1, 5'd9, 1'b1, 32'h99);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t5_blk_mdu_ready", 64'(bus.mdu_wbck_ready), 64'd0);
            check("t5_blk_clr_req", 64'(bus.clr_req), 64'd0);
            step();
        end
        @(negedge clk);
        check("t5_force_mdu_ready", 64'(bus.mdu_wbck_ready), 64'd1);
        check("t5_force_clr_req", 64'(bus.clr_req), 64'd1);
        check("t5_force_clr_idx", 64'(bus.clr_idx), 64'd8);
        push(5'd9, 1'b1, 32'h99);
        step();
        bus.alu_wbck_valid = 1'b0;
        drive_mdu(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("t5_mdu_clr_req", 64'(bus.clr_req), 64'd1);
        check("t5_mdu_clr_idx", 64'(bus.clr_idx), 64'd9);
        step();

        // Reset while an entry is staged and rr_ptr favours the MDU.
        bus.alu_wbck_valid = 1'b1;
        drive_lsu(1'b1, 5'd12, 1'b1, 32'hC);
        @(negedge clk);
        check("t6_lsu_ready", 64'(bus.lsu_wbck_ready), 64'd1);
        push(5'd12, 1'b1, 32'hC);
        step();
        drive_lsu(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        step();
        rst = 1'b0;
        sb.delete();
        step();
        @(negedge clk);
        check("t6_rst_clr_req", 64'(bus.clr_req), 64'd0);
        check("t6_rst_rf_wen", 64'(bus.rf_wen), 64'd0);
        check("t6_rst_alu_ready", 64'(bus.alu_wbck_ready), 64'd1);
        step();
        rst = 1'b1;
        bus.alu_wbck_valid = 1'b0;
        drive_lsu(1'b1, 5'd13, 1'b1, 32'hD);
        drive_mdu(1'b1, 5'd14, 1'b1, 32'hE);
        @(negedge clk);
        check("t6_rel_lsu_ready", 64'(bus.lsu_wbck_ready), 64'd1);
        check("t6_rel_mdu_ready", 64'(bus.mdu_wbck_ready), 64'd0);
        push(5'd13, 1'b1, 32'hD);
        step();
        drive_lsu(1'b0, '0, 1'b0, '0);
        drive_mdu(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("t6_rel_clr_idx", 64'(bus.clr_idx), 64'd13);
        step();
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/longp_wbck_arb.md
# longp_wbck_arb

Long-pipe write-back arbiter. It collects completions from the two long-latency units, the LSU and the multiply/divide unit (MDU), and picks one per cycle with round-robin arbitration. The winner is held in a single registered write-back stage. That stage shares the register-file write port with the ALU write-back and drives `clr_req`/`clr_idx` into the outstanding-instruction FIFO, so each commit retires one OITF entry in the same cycle as its register write.

## Interface
- `XLEN`, 32, data width of write-back values
- `RAW`, 5, register index width
- `STARVE_MAX`, 4, consecutive blocked cycles tolerated before the ALU is stalled; legal range 1..15
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `lsu_wbck_valid`  in  1  LSU completion valid
- `lsu_wbck_ready`  out  1  LSU completion accepted
- `lsu_wbck_rdidx`  in  RAW  destination register
- `lsu_wbck_rdwen`  in  1  destination write required
- `lsu_wbck_wdata`  in  XLEN  result
- `mdu_wbck_valid` / `mdu_wbck_ready` / `mdu_wbck_rdidx` / `mdu_wbck_rdwen` / `mdu_wbck_wdata`  same directions and widths as the LSU ports, for the MDU
- `alu_wbck_valid`  in  1  ALU is writing the regfile this cycle
- `alu_wbck_ready`  out  1  ALU write permitted; low only during a forced long commit
- `rf_wen`  out  1  long-pipe regfile write enable
- `rf_waddr`  out  RAW  write address
- `rf_wdata`  out  XLEN  write data
- `clr_req`  out  1  retire one OITF entry
- `clr_idx`  out  RAW  register index of the retiring entry

## Operation
- State:
  - stage register: `wb_vld`, `wb_rdidx`, `wb_rdwen`, `wb_wdata`
  - round-robin pointer `rr_ptr` (0 = LSU preferred)
  - starvation counter `starve_cnt`, 4 bits
- `force = wb_vld & (starve_cnt == STARVE_MAX)`.
- `commit = wb_vld & (~alu_wbck_valid | force)`.
- `alu_wbck_ready = ~force`.
  - When `force` is high and the ALU is valid, the ALU holds its write; this block does not check that.
- Outputs during commit:
  - `clr_req = commit`, `clr_idx = wb_rdidx`.
  - `rf_wen = commit & wb_rdwen & (wb_rdidx != 0)`.
  - `rf_waddr = wb_rdidx`, `rf_wdata = wb_wdata`.
- A commit with no regfile write (`wb_rdwen == 0`, or rd = x0) still asserts `clr_req`.
- Stage load:
  - `load_en = ~wb_vld | commit` (pipelined refill, so a back-to-back stream commits one entry per cycle).
- Arbitration, evaluated only when `load_en` is high:
  - Both sources valid: grant the source selected by `rr_ptr`.
  - One source valid: grant that source.
  - `src_ready = load_en & grant_src`. No source sees ready while `load_en` is low.
  - Source ready never depends on the same source's data.
- On a handshake:
  - The stage captures the granted source's `{rdidx, rdwen, wdata}` and sets `wb_vld`.
  - `rr_ptr` is set to point at the source that was not granted.
- On commit with no handshake: `wb_vld` clears.
- Starvation counter:
  - Cleared on commit and whenever `wb_vld` is low.
  - Incremented when `wb_vld & alu_wbck_valid & ~force`.
  - Saturates at `STARVE_MAX`.
- The stage contents are held unchanged while blocked.

## Timing
- Reset (`rst` low at a clock edge) clears:
  - `wb_vld`, `rr_ptr`, `starve_cnt` to 0
  - `rf_wen`, `clr_req` to 0
  - `lsu_wbck_ready` and `mdu_wbck_ready` reflect the empty stage (ready to the granted valid source)
  - `alu_wbck_ready` to 1
- Reset mid-operation drops the staged entry without a `clr_req`. The OITF is reset in the same cycle.
- Latency:
  - Source handshake in cycle N gives `rf_wen`/`clr_req` in cycle N+1 if `alu_wbck_valid` is low in N+1.
  - Each ALU-valid cycle adds one cycle, up to `STARVE_MAX`.
  - Worst case: commit in cycle N+1+`STARVE_MAX`, with `alu_wbck_ready` low only in that cycle.
- Commit outputs are combinational from the stage register and `alu_wbck_valid`. The regfile write and the OITF clear take effect at the same edge.
- Throughput: 1 completion per cycle with the ALU idle. Handshake and commit in the same cycle are legal.
- Simultaneous commit and refill: the new entry appears the next cycle. `starve_cnt` restarts at 0.

## Test plan
- Single LSU completion (`rdidx=5`, `wdata=0xDEADBEEF`, `rdwen=1`), ALU idle: `lsu_wbck_ready`=1 in cycle 0; cycle 1 shows `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `clr_req`=1, `clr_idx`=5; both outputs 0 in cycle 2.
- LSU and MDU both held valid for 4 cycles, ALU idle: grants go LSU, MDU, LSU, MDU; `clr_idx` follows the same order one cycle later; no bubbles.
- Staged entry (`rdidx=7`) with `alu_wbck_valid` held high, `STARVE_MAX=4`: no commit for 4 cycles; 5th cycle has `alu_wbck_ready`=0 and `rf_wen`=`clr_req`=1, `clr_idx`=7.
- MDU completion with `rdidx=0`, `rdwen=1`: `rf_wen`=0 and `clr_req`=1 with `clr_idx`=0. Repeat with `rdidx=3`, `rdwen=0`: `rf_wen`=0, `clr_req`=1, `clr_idx`=3.
- Stage full and blocked by the ALU while the MDU is valid: `mdu_wbck_ready`=0 until the commit cycle, then 1 in that cycle; the MDU entry commits the next cycle.
- `rst` asserted while an entry is staged: next cycle `clr_req`=0, `rf_wen`=0, `alu_wbck_ready`=1; after release the first grant goes to the LSU when both sources are valid.
